// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcodes, ALU/special-instruction enums and decoded bundle for decode_stage
package decode_pkg;

    localparam int INST_W = 32;
    localparam int XLEN_W = 64;
    localparam int REG_W  = 5;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Bit positions inside the 5-bit enables vector
    localparam int EN_RS1    = 0;
    localparam int EN_RS2    = 1;
    localparam int EN_RD     = 2;
    localparam int EN_MREAD  = 3;
    localparam int EN_MWRITE = 4;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,  ALU_SUB   = 5'd1,  ALU_OR    = 5'd2,  ALU_AND   = 5'd3,
        ALU_XOR   = 5'd4,  ALU_SLL   = 5'd5,  ALU_SRL   = 5'd6,  ALU_SRA   = 5'd7,
        ALU_EQ    = 5'd8,  ALU_SLT   = 5'd9,  ALU_SLTU  = 5'd10, ALU_COPYB = 5'd11,
        ALU_ADDW  = 5'd12, ALU_SUBW  = 5'd13, ALU_SLLW  = 5'd14, ALU_SRLW  = 5'd15,
        ALU_SRAW  = 5'd16, ALU_MUL   = 5'd17, ALU_MULH  = 5'd18, ALU_MULHSU = 5'd19,
        ALU_MULHU = 5'd20, ALU_DIV   = 5'd21, ALU_DIVU  = 5'd22, ALU_REM   = 5'd23,
        ALU_REMU  = 5'd24, ALU_MULW  = 5'd25, ALU_DIVW  = 5'd26, ALU_DIVUW = 5'd27,
        ALU_REMW  = 5'd28, ALU_REMUW = 5'd29
    } alu_op_e;

    typedef enum logic [2:0] {
        SI_BR = 3'd0, SI_JAL = 3'd1, SI_JALR = 3'd2, SI_AUIPC = 3'd3,
        SI_LUI = 3'd4, SI_STORE = 3'd5, SI_LOAD = 3'd6, SI_NONE = 3'd7
    } spec_e;

    typedef struct packed {
        logic [4:0]        enables;
        alu_op_e           aluop;
        spec_e             specinst;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [2:0]        funct3;
        logic [XLEN_W-1:0] imm;
        logic              illegal;
        logic [1:0]        env;
    } decoded_t;

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and execute-side handshake bundle of decode_stage
// master: upstream/downstream driver (drives in_*, out_ready); slave: decode_stage
interface decode_stage_if #(
    parameter int INST_WIDTH = 32,
    parameter int XLEN       = 64,
    parameter int RF_SIZE    = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [INST_WIDTH-1:0] in_inst;
    logic [XLEN-1:0]       in_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_pc;
    logic [4:0]            out_enables;
    logic [4:0]            out_aluop;
    logic [2:0]            out_specinst;
    logic [RF_SIZE-1:0]    out_rs1;
    logic [RF_SIZE-1:0]    out_rs2;
    logic [RF_SIZE-1:0]    out_rd;
    logic [2:0]            out_funct3;
    logic [XLEN-1:0]       out_imm;
    logic                  out_illegal;
    logic [1:0]            out_env;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_enables, out_aluop, out_specinst,
               out_rs1, out_rs2, out_rd, out_funct3, out_imm, out_illegal, out_env
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_enables, out_aluop, out_specinst,
               out_rs1, out_rs2, out_rd, out_funct3, out_imm, out_illegal, out_env
    );
endinterface

// File: rtl/decode_logic.sv
// rtl/decode_logic.sv - combinational RV64I(+M) instruction decoder
// inst: 32-bit instruction in; dec: decoded bundle out
module decode_logic
    import decode_pkg::*;
#(
    parameter bit EN_M = 1'b0
) (
    input  logic [INST_W-1:0] inst,
    output decoded_t          dec
);
    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [XLEN_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic              illegal;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];

    assign imm_i = {{52{inst[31]}}, inst[31:20]};
    assign imm_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {{32{inst[31]}}, inst[31:12], 12'b0};
    assign imm_j = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        dec          = '0;
        dec.aluop    = ALU_ADD;
        dec.specinst = SI_NONE;
        dec.rs1      = inst[19:15];
        dec.rs2      = inst[24:20];
        dec.rd       = inst[11:7];
        dec.funct3   = f3;
        illegal      = 1'b0;
        case (opc)
            OPC_LOAD: begin
                dec.enables[EN_RS1]   = 1'b1;
                dec.enables[EN_RD]    = 1'b1;
                dec.enables[EN_MREAD] = 1'b1;
                dec.specinst = SI_LOAD;
                dec.imm      = imm_i;
                illegal      = (f3 == 3'b111);
            end
            OPC_STORE: begin
                dec.enables[EN_RS1]    = 1'b1;
                dec.enables[EN_RS2]    = 1'b1;
                dec.enables[EN_MWRITE] = 1'b1;
                dec.specinst = SI_STORE;
                dec.imm      = imm_s;
                illegal      = f3[2];
            end
            OPC_BRANCH: begin
                dec.enables[EN_RS1] = 1'b1;
                dec.enables[EN_RS2] = 1'b1;
                dec.specinst = SI_BR;
                dec.imm      = imm_b;
                case (f3[2:1])
                    2'b00:   dec.aluop = ALU_EQ;
                    2'b10:   dec.aluop = ALU_SLT;
                    2'b11:   dec.aluop = ALU_SLTU;
                    default: illegal   = 1'b1;
                endcase
            end
            OPC_JAL: begin
                dec.enables[EN_RD] = 1'b1;
                dec.specinst = SI_JAL;
                dec.imm      = imm_j;
            end
            OPC_JALR: begin
                dec.enables[EN_RS1] = 1'b1;
                dec.enables[EN_RD]  = 1'b1;
                dec.specinst = SI_JALR;
                dec.imm      = imm_i;
            end
            OPC_LUI: begin
                dec.enables[EN_RD] = 1'b1;
                dec.specinst = SI_LUI;
                dec.aluop    = ALU_COPYB;
                dec.imm      = imm_u;
            end
            OPC_AUIPC: begin
                dec.enables[EN_RD] = 1'b1;
                dec.specinst = SI_AUIPC;
                dec.imm      = imm_u;
            end
            OPC_OP_IMM: begin
                dec.enables[EN_RS1] = 1'b1;
                dec.enables[EN_RD]  = 1'b1;
                dec.imm = imm_i;
                case (f3)
                    3'b001:  dec.aluop = ALU_SLL;
                    3'b010:  dec.aluop = ALU_SLT;
                    3'b011:  dec.aluop = ALU_SLTU;
                    3'b100:  dec.aluop = ALU_XOR;
                    3'b101:  dec.aluop = inst[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  dec.aluop = ALU_OR;
                    3'b111:  dec.aluop = ALU_AND;
                    default: dec.aluop = ALU_ADD;
                endcase
            end
            OPC_OP_IMM32: begin
                dec.enables[EN_RS1] = 1'b1;
                dec.enables[EN_RD]  = 1'b1;
                dec.imm = imm_i;
                case (f3)
                    3'b001:  dec.aluop = ALU_SLLW;
                    3'b101:  dec.aluop = inst[30] ? ALU_SRAW : ALU_SRLW;
                    default: dec.aluop = ALU_ADDW;
                endcase
            end
            OPC_OP: begin
                dec.enables[EN_RS1] = 1'b1;
                dec.enables[EN_RS2] = 1'b1;
                dec.enables[EN_RD]  = 1'b1;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'b000:  dec.aluop = ALU_ADD;
                        3'b001:  dec.aluop = ALU_SLL;
                        3'b010:  dec.aluop = ALU_SLT;
                        3'b011:  dec.aluop = ALU_SLTU;
                        3'b100:  dec.aluop = ALU_XOR;
                        3'b101:  dec.aluop = ALU_SRL;
                        3'b110:  dec.aluop = ALU_OR;
                        default: dec.aluop = ALU_AND;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'b000) begin
                    dec.aluop = ALU_SUB;
                end else if (f7 == 7'h20 && f3 == 3'b101) begin
                    dec.aluop = ALU_SRA;
                end else if (f7 == 7'h01 && EN_M) begin
                    // MUL..REMU are laid out in funct3 order from 17
                    dec.aluop = alu_op_e'(5'd17 + {2'b00, f3});
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP32: begin
                dec.enables[EN_RS1] = 1'b1;
                dec.enables[EN_RS2] = 1'b1;
                dec.enables[EN_RD]  = 1'b1;
                if (f7 == 7'h01 && EN_M) begin
                    case (f3)
                        3'b000:  dec.aluop = ALU_MULW;
                        3'b100:  dec.aluop = ALU_DIVW;
                        3'b101:  dec.aluop = ALU_DIVUW;
                        3'b110:  dec.aluop = ALU_REMW;
                        3'b111:  dec.aluop = ALU_REMUW;
                        default: illegal   = 1'b1;
                    endcase
                end else if (f7 == 7'h00) begin
                    case (f3)
                        3'b000:  dec.aluop = ALU_ADDW;
                        3'b001:  dec.aluop = ALU_SLLW;
                        3'b101:  dec.aluop = ALU_SRLW;
                        default: illegal   = 1'b1;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'b000) begin
                    dec.aluop = ALU_SUBW;
                end else if (f7 == 7'h20 && f3 == 3'b101) begin
                    dec.aluop = ALU_SRAW;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                if (f3 == 3'b000 && inst[31:20] == 12'h000) begin
                    dec.env = 2'b01;
                end else if (f3 == 3'b000 && inst[31:20] == 12'h001) begin
                    dec.env = 2'b10;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                // fence: ordering is trivially satisfied in-order, decode as a no-op
            end
            default: illegal = 1'b1;
        endcase
        // Illegal entries travel down the pipe but must not touch state
        if (illegal) begin
            dec.enables  = '0;
            dec.specinst = SI_NONE;
            dec.env      = 2'b00;
        end
        dec.illegal = illegal;
    end
endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - buffered handshaked decode stage: decoder, DEPTH-entry FIFO, serialising FSM
// clk, rst_n (async active-low), flush; io: decode_stage_if.slave; count: FIFO occupancy
module decode_stage
    import decode_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int XLEN       = 64,
    parameter int RF_SIZE    = 5,
    parameter int DEPTH      = 4,
    parameter bit EN_M       = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    decode_stage_if.slave            io,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {ST_RUN, ST_SERIALIZE} state_e;

    decoded_t        in_dec;
    decoded_t        head;
    decoded_t        dec_mem [DEPTH];
    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt, cnt_nxt;
    state_e          state;
    logic            in_ready_q;
    logic            push, pop, serialize_in;

    decode_logic #(.EN_M(EN_M)) u_decode_logic (
        .inst (io.in_inst[INST_WIDTH-1:0]),
        .dec  (in_dec)
    );

    assign push         = io.in_valid && in_ready_q && !flush;
    assign pop          = (cnt != '0) && io.out_ready && !flush;
    assign serialize_in = in_dec.illegal || (in_dec.env != 2'b00);
    assign cnt_nxt      = cnt + CW'(push) - CW'(pop);

    // in_ready is registered from next-state values so it never sees out_ready combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            in_ready_q <= 1'b0;
        end else if (flush) begin
            state      <= ST_RUN;
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            cnt <= cnt_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case (state)
                ST_RUN: begin
                    if (push && serialize_in) begin
                        state      <= ST_SERIALIZE;
                        in_ready_q <= 1'b0;
                    end else begin
                        in_ready_q <= (cnt_nxt != CW'(DEPTH));
                    end
                end
                default: begin
                    // The serialising entry is the youngest, so popping it with cnt==1 drains the FIFO
                    if (pop && cnt == CW'(1)) begin
                        state      <= ST_RUN;
                        in_ready_q <= 1'b1;
                    end else begin
                        in_ready_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dec_mem[wr_ptr] <= in_dec;
            pc_mem[wr_ptr]  <= io.in_pc;
        end
    end

    assign head            = dec_mem[rd_ptr];
    assign io.in_ready     = in_ready_q;
    assign io.out_valid    = (cnt != '0);
    assign io.out_pc       = pc_mem[rd_ptr];
    assign io.out_enables  = head.enables;
    assign io.out_aluop    = head.aluop;
    assign io.out_specinst = head.specinst;
    assign io.out_rs1      = head.rs1[RF_SIZE-1:0];
    assign io.out_rs2      = head.rs2[RF_SIZE-1:0];
    assign io.out_rd       = head.rd[RF_SIZE-1:0];
    assign io.out_funct3   = head.funct3;
    assign io.out_imm      = head.imm[XLEN-1:0];
    assign io.out_illegal  = head.illegal;
    assign io.out_env      = head.env;
    assign count           = cnt;
endmodule
